// File: rtl/rotate_step_gen.sv
// Step sequencer for the rotating seven-segment pattern: synchronizes the switches,
// prescales the clock to the step rate and emits the pattern index with its direction.
module rotate_step_gen #(
  parameter int DIV_BASE = 12_500_000,
  parameter int CNT_W    = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       cw,
  input  logic [1:0] speed,
  output logic [2:0] pos,
  output logic       cw_out,
  output logic       step
);

  localparam logic [CNT_W-1:0] DIV_BASE_W = CNT_W'(DIV_BASE);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic             en_m, en_s;
  logic             cw_m, cw_s;
  logic [1:0]       speed_m, speed_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] term;
  logic             dir_change;
  logic             tick;

  // Synchronizer stage: two flops per asynchronous switch input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_m    <= 1'b0;
      en_s    <= 1'b0;
      cw_m    <= 1'b0;
      cw_s    <= 1'b0;
      speed_m <= 2'b00;
      speed_s <= 2'b00;
    end else begin
      en_m    <= en;
      en_s    <= en_m;
      cw_m    <= cw;
      cw_s    <= cw_m;
      speed_m <= speed;
      speed_s <= speed_m;
    end
  end

  // The >= compare lets a speed-up that strands cnt past the new terminal wrap at once
  always_comb begin
    div        = DIV_BASE_W >> speed_s;
    term       = div - ONE;
    dir_change = (cw_s != cw_out);
    tick       = en_s && (cnt >= term);
  end

  // Sequencer stage: direction change restarts at the shared start segment and eats any tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      pos    <= 3'd0;
      cw_out <= 1'b0;
      step   <= 1'b0;
    end else if (dir_change) begin
      cnt    <= '0;
      pos    <= 3'd0;
      cw_out <= cw_s;
      step   <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      pos  <= pos + 3'd1;
      step <= 1'b1;
    end else if (en_s) begin
      cnt  <= cnt + ONE;
      step <= 1'b0;
    end else begin
      step <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rotate_step_gen.sv
// Bench for rotate_step_gen with DIV_BASE=8: vector table run through a scoreboard queue,
// plus hand-written sequences for asynchronous reset and direction-from-reset cases.
module tb_rotate_step_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic       cw;
  logic [1:0] speed;
  logic [2:0] pos;
  logic       cw_out;
  logic       step;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  typedef struct {
    logic       en;
    logic       cw;
    logic [1:0] speed;
    int         ncyc;
    int         pos;
    int         cwo;
    int         stp;
    int         pulses;
  } vec_t;

  vec_t vecs[35];
  vec_t sb[$];

  rotate_step_gen #(.DIV_BASE(8), .CNT_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .cw     (cw),
    .speed  (speed),
    .pos    (pos),
    .cw_out (cw_out),
    .step   (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each one.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (step === 1'b1) pulses++;
    end
  endtask

  task automatic check_out(input string tag, input int p, input int c, input int s);
    check({tag, "_pos"}, int'(pos), p);
    check({tag, "_cw_out"}, int'(cw_out), c);
    check({tag, "_step"}, int'(step), s);
  endtask

  initial begin
    // en, cw, speed, cycles, pos, cw_out, step, cumulative step pulses
    vecs[0]  = '{1'b1, 1'b0, 2'd0,  9, 0, 0, 0,  0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0,  1, 1, 0, 1,  1};
    vecs[2]  = '{1'b1, 1'b0, 2'd0,  1, 1, 0, 0,  1};
    vecs[3]  = '{1'b1, 1'b0, 2'd0,  7, 2, 0, 1,  2};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 40, 7, 0, 1,  7};
    vecs[5]  = '{1'b1, 1'b0, 2'd0,  8, 0, 0, 1,  8};
    vecs[6]  = '{1'b1, 1'b0, 2'd2,  3, 1, 0, 1,  9};
    vecs[7]  = '{1'b1, 1'b0, 2'd2,  1, 1, 0, 0,  9};
    vecs[8]  = '{1'b1, 1'b0, 2'd0,  1, 2, 0, 1, 10};
    vecs[9]  = '{1'b1, 1'b0, 2'd0,  7, 2, 0, 0, 10};
    vecs[10] = '{1'b1, 1'b0, 2'd0,  1, 3, 0, 1, 11};
    vecs[11] = '{1'b1, 1'b0, 2'd0,  3, 3, 0, 0, 11};
    vecs[12] = '{1'b1, 1'b0, 2'd3,  2, 3, 0, 0, 11};
    vecs[13] = '{1'b1, 1'b0, 2'd3,  1, 4, 0, 1, 12};
    vecs[14] = '{1'b1, 1'b0, 2'd3,  1, 5, 0, 1, 13};
    vecs[15] = '{1'b1, 1'b0, 2'd0,  2, 7, 0, 1, 15};
    vecs[16] = '{1'b1, 1'b0, 2'd0,  1, 7, 0, 0, 15};
    vecs[17] = '{1'b1, 1'b0, 2'd0,  7, 0, 0, 1, 16};
    vecs[18] = '{1'b1, 1'b0, 2'd0, 24, 3, 0, 1, 19};
    vecs[19] = '{1'b1, 1'b0, 2'd0,  2, 3, 0, 0, 19};
    vecs[20] = '{1'b0, 1'b0, 2'd0, 50, 3, 0, 0, 19};
    vecs[21] = '{1'b0, 1'b0, 2'd0,  2, 3, 0, 0, 19};
    vecs[22] = '{1'b1, 1'b0, 2'd0,  5, 3, 0, 0, 19};
    vecs[23] = '{1'b1, 1'b0, 2'd0,  1, 4, 0, 1, 20};
    vecs[24] = '{1'b1, 1'b0, 2'd0,  8, 5, 0, 1, 21};
    vecs[25] = '{1'b1, 1'b0, 2'd0,  2, 5, 0, 0, 21};
    vecs[26] = '{1'b1, 1'b1, 2'd0,  2, 5, 0, 0, 21};
    vecs[27] = '{1'b1, 1'b1, 2'd0,  1, 0, 1, 0, 21};
    vecs[28] = '{1'b1, 1'b1, 2'd0,  7, 0, 1, 0, 21};
    vecs[29] = '{1'b1, 1'b1, 2'd0,  1, 1, 1, 1, 22};
    vecs[30] = '{1'b1, 1'b1, 2'd0,  5, 1, 1, 0, 22};
    vecs[31] = '{1'b1, 1'b0, 2'd0,  2, 1, 1, 0, 22};
    vecs[32] = '{1'b1, 1'b0, 2'd0,  1, 0, 0, 0, 22};
    vecs[33] = '{1'b1, 1'b0, 2'd0,  8, 1, 0, 1, 23};
    vecs[34] = '{1'b1, 1'b0, 2'd0, 40, 6, 0, 1, 28};

    reset = 1'b1;
    en    = 1'b1;
    cw    = 1'b0;
    speed = 2'd0;
    run(3);
    check_out("reset_state", 0, 0, 0);

    reset  = 1'b0;
    pulses = 0;

    for (int i = 0; i < 35; i++) begin
      vec_t exp_v;
      en    = vecs[i].en;
      cw    = vecs[i].cw;
      speed = vecs[i].speed;
      sb.push_back(vecs[i]);
      run(vecs[i].ncyc);
      exp_v = sb.pop_front();
      check_out($sformatf("row%0d", i), exp_v.pos, exp_v.cwo, exp_v.stp);
      check($sformatf("row%0d_pulses", i), pulses, exp_v.pulses);
    end

    // Reset between edges right after the step to pos 6
    #3;
    reset = 1'b1;
    #1;
    check_out("async_reset", 0, 0, 0);
    run(2);
    check_out("reset_held", 0, 0, 0);
    reset  = 1'b0;
    pulses = 0;
    run(9);
    check_out("restart_wait", 0, 0, 0);
    run(1);
    check_out("restart_first", 1, 0, 1);

    // cw already high with en low when reset releases
    reset = 1'b1;
    en    = 1'b0;
    cw    = 1'b1;
    run(2);
    reset  = 1'b0;
    pulses = 0;
    run(2);
    check_out("cw_sync_pending", 0, 0, 0);
    run(1);
    check_out("cw_applied", 0, 1, 0);
    run(20);
    check_out("cw_paused", 0, 1, 0);
    check("cw_paused_pulses", pulses, 0);

    // Run clockwise, then reset mid-count must clear cw_out too
    en = 1'b1;
    run(9);
    check_out("cw_run_wait", 0, 1, 0);
    run(1);
    check_out("cw_run_first", 1, 1, 1);
    run(3);
    #4;
    reset = 1'b1;
    #1;
    check_out("cw_async_reset", 0, 0, 0);
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
